// File: rtl/edulent_pkg.sv
// Shared definitions for the Edulent CPU control path: transfer commands, opcodes,
// instruction classes, sequencer states and the per-class micro-op table.
package edulent_pkg;

    localparam logic [3:0] XFER_NONE    = 4'h0;
    localparam logic [3:0] XFER_MA_PC   = 4'h1;
    localparam logic [3:0] XFER_MD_MEM  = 4'h2;
    localparam logic [3:0] XFER_IR_MD   = 4'h3;
    localparam logic [3:0] XFER_MA_MD   = 4'h4;
    localparam logic [3:0] XFER_DST_MD  = 4'h5;
    localparam logic [3:0] XFER_MA_DP   = 4'h6;
    localparam logic [3:0] XFER_MA_SP   = 4'h7;
    localparam logic [3:0] XFER_MD_SRC  = 4'h8;
    localparam logic [3:0] XFER_MEM_MD  = 4'h9;
    localparam logic [3:0] XFER_DST_R   = 4'hA;
    localparam logic [3:0] XFER_PC_MD   = 4'hB;
    localparam logic [3:0] XFER_DST_IN  = 4'hC;
    localparam logic [3:0] XFER_OUT_SRC = 4'hD;
    localparam logic [3:0] XFER_PC_TGT  = 4'hE;
    localparam logic [3:0] XFER_MD_PC   = 4'hF;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LDI_A = 8'h19;
    localparam logic [7:0] OP_LDI_B = 8'h1B;
    localparam logic [7:0] OP_LDD_A = 8'h11;
    localparam logic [7:0] OP_LDD_B = 8'h13;
    localparam logic [7:0] OP_LDX_A = 8'h14;
    localparam logic [7:0] OP_LDX_B = 8'h1E;
    localparam logic [7:0] OP_POP   = 8'hC1;
    localparam logic [7:0] OP_STD_A = 8'h21;
    localparam logic [7:0] OP_STD_B = 8'h23;
    localparam logic [7:0] OP_PSH_A = 8'h2C;
    localparam logic [7:0] OP_PSH_B = 8'h2E;
    localparam logic [7:0] OP_JMP_A = 8'hA1;
    localparam logic [7:0] OP_JMP_B = 8'hA5;
    localparam logic [7:0] OP_JMP_C = 8'hA9;
    localparam logic [7:0] OP_RET   = 8'hB0;
    localparam logic [7:0] OP_CAL   = 8'hE0;
    localparam logic [7:0] OP_IN    = 8'hF0;
    localparam logic [7:0] OP_OUT   = 8'hF1;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    localparam logic [2:0] STEP_MAX = 3'd4;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_LDI, CLS_LDD, CLS_LDX, CLS_POP, CLS_STD, CLS_PSH, CLS_ALI,
        CLS_ALU, CLS_JMP, CLS_RET, CLS_CAL, CLS_IN,  CLS_OUT, CLS_HLT
    } instr_class_t;

    typedef enum logic [2:0] {
        IDLE, FETCH0, FETCH1, FETCH2, DECODE, EXEC, HALT
    } cu_state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       inc_pc;
        logic [1:0] sp;
        logic       calc;
    } uop_t;

    function automatic uop_t mk_uop(logic [3:0] cmd, logic inc_pc, logic [1:0] sp, logic calc);
        return {cmd, inc_pc, sp, calc};
    endfunction

    function automatic uop_t xf(logic [3:0] cmd);
        return mk_uop(cmd, 1'b0, SP_HOLD, 1'b0);
    endfunction

    // Operand fetch: MA <= PC and advance PC past the immediate byte
    function automatic uop_t imm_fetch();
        return mk_uop(XFER_MA_PC, 1'b1, SP_HOLD, 1'b0);
    endfunction

    function automatic logic [2:0] class_last_step(instr_class_t cls);
        case (cls)
            CLS_LDD, CLS_STD:                   return 3'd4;
            CLS_POP, CLS_ALI, CLS_RET, CLS_CAL: return 3'd3;
            CLS_LDI, CLS_LDX, CLS_PSH, CLS_JMP: return 3'd2;
            CLS_ALU:                            return 3'd1;
            default:                            return 3'd0;
        endcase
    endfunction

    function automatic uop_t exec_uop(instr_class_t cls, logic [2:0] step);
        uop_t u;
        u = xf(XFER_NONE);
        case (cls)
            CLS_LDI: case (step)
                3'd0: u = imm_fetch();
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = xf(XFER_DST_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_LDD: case (step)
                3'd0: u = imm_fetch();
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = xf(XFER_MA_MD);
                3'd3: u = xf(XFER_MD_MEM);
                3'd4: u = xf(XFER_DST_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_LDX: case (step)
                3'd0: u = xf(XFER_MA_DP);
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = xf(XFER_DST_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_POP: case (step)
                3'd0: u = mk_uop(XFER_NONE, 1'b0, SP_INC, 1'b0);
                3'd1: u = xf(XFER_MA_SP);
                3'd2: u = xf(XFER_MD_MEM);
                3'd3: u = xf(XFER_DST_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_STD: case (step)
                3'd0: u = imm_fetch();
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = xf(XFER_MA_MD);
                3'd3: u = xf(XFER_MD_SRC);
                3'd4: u = xf(XFER_MEM_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_PSH: case (step)
                3'd0: u = xf(XFER_MA_SP);
                3'd1: u = xf(XFER_MD_SRC);
                3'd2: u = mk_uop(XFER_MEM_MD, 1'b0, SP_DEC, 1'b0);
                default: u = xf(XFER_NONE);
            endcase
            CLS_ALI: case (step)
                3'd0: u = imm_fetch();
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = mk_uop(XFER_NONE, 1'b0, SP_HOLD, 1'b1);
                3'd3: u = xf(XFER_DST_R);
                default: u = xf(XFER_NONE);
            endcase
            CLS_ALU: case (step)
                3'd0: u = mk_uop(XFER_NONE, 1'b0, SP_HOLD, 1'b1);
                3'd1: u = xf(XFER_DST_R);
                default: u = xf(XFER_NONE);
            endcase
            CLS_JMP: case (step)
                3'd0: u = imm_fetch();
                3'd1: u = xf(XFER_MD_MEM);
                3'd2: u = xf(XFER_PC_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_RET: case (step)
                3'd0: u = mk_uop(XFER_NONE, 1'b0, SP_INC, 1'b0);
                3'd1: u = xf(XFER_MA_SP);
                3'd2: u = xf(XFER_MD_MEM);
                3'd3: u = xf(XFER_PC_MD);
                default: u = xf(XFER_NONE);
            endcase
            CLS_CAL: case (step)
                3'd0: u = xf(XFER_MA_SP);
                3'd1: u = xf(XFER_MD_PC);
                3'd2: u = mk_uop(XFER_MEM_MD, 1'b0, SP_DEC, 1'b0);
                3'd3: u = xf(XFER_PC_TGT);
                default: u = xf(XFER_NONE);
            endcase
            CLS_IN:  u = (step == 3'd0) ? xf(XFER_DST_IN)  : xf(XFER_NONE);
            CLS_OUT: u = (step == 3'd0) ? xf(XFER_OUT_SRC) : xf(XFER_NONE);
            default: u = xf(XFER_NONE);
        endcase
        return u;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> data_path bundle: run permission and IR in, micro-op commands out.
interface control_unit_if;
    import edulent_pkg::*;

    logic       i_run;
    logic [7:0] i_ir;
    logic [3:0] o_transfer_cmd;
    logic       o_inc_pc;
    logic [1:0] o_inc_dec_sp;
    logic       o_alu_calculate;
    logic       o_alu_res_to_ap;
    logic       o_reset_ir;
    logic       o_next_instr;
    logic       o_halted;

    modport master (
        input  i_run, i_ir,
        output o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
               o_alu_res_to_ap, o_reset_ir, o_next_instr, o_halted
    );

    modport slave (
        output i_run, i_ir,
        input  o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
               o_alu_res_to_ap, o_reset_ir, o_next_instr, o_halted
    );
endinterface

// File: rtl/control_unit_instr_decode.sv
// Combinational opcode classifier: maps an IR byte to its execute class and final step.
module instr_decode
    import edulent_pkg::*;
(
    input  logic [7:0]   i_opcode,
    output instr_class_t o_class,
    output logic [2:0]   o_last_step
);

    always_comb begin
        o_class = CLS_NOP;
        case (i_opcode)
            OP_NOP:             o_class = CLS_NOP;
            OP_LDI_A, OP_LDI_B: o_class = CLS_LDI;
            OP_LDD_A, OP_LDD_B: o_class = CLS_LDD;
            OP_LDX_A, OP_LDX_B: o_class = CLS_LDX;
            OP_POP:             o_class = CLS_POP;
            OP_STD_A, OP_STD_B: o_class = CLS_STD;
            OP_PSH_A, OP_PSH_B: o_class = CLS_PSH;
            OP_JMP_A, OP_JMP_B, OP_JMP_C: o_class = CLS_JMP;
            OP_RET:             o_class = CLS_RET;
            OP_CAL:             o_class = CLS_CAL;
            OP_IN:              o_class = CLS_IN;
            OP_OUT:             o_class = CLS_OUT;
            OP_HLT:             o_class = CLS_HLT;
            // ALU families are whole high nibbles; everything else is treated as NOP
            default: case (i_opcode[7:4])
                4'h3, 4'h6, 4'h7, 4'h8: o_class = CLS_ALI;
                4'h5, 4'h9:             o_class = CLS_ALU;
                default:                o_class = CLS_NOP;
            endcase
        endcase
    end

    assign o_last_step = class_last_step(o_class);

endmodule

// File: rtl/control_unit.sv
// Edulent microsequencer: fetch, decode and per-class execute sequencing, driving
// every data_path control input as a Moore decode of {state, class, step}.
module control_unit
    import edulent_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    control_unit_if.master bus
);

    cu_state_t    r_state,     w_state_nxt;
    logic [2:0]   r_step,      w_step_nxt;
    instr_class_t r_class,     w_class_nxt;
    logic [2:0]   r_last_step, w_last_nxt;
    logic         r_ap,        w_ap_nxt;

    instr_class_t w_dec_class;
    logic [2:0]   w_dec_last;
    logic         w_go;
    uop_t         w_uop;
    logic         w_alu_ap;
    logic         w_reset_ir;
    logic         w_next_instr;
    logic         w_halted;

    instr_decode u_decode (
        .i_opcode    (bus.i_ir),
        .o_class     (w_dec_class),
        .o_last_step (w_dec_last)
    );

    assign w_go = bus.i_run | AUTO_RUN;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_step      <= 3'd0;
            r_class     <= CLS_NOP;
            r_last_step <= 3'd0;
            r_ap        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_class     <= w_class_nxt;
            r_last_step <= w_last_nxt;
            r_ap        <= w_ap_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_class_nxt  = r_class;
        w_last_nxt   = r_last_step;
        w_ap_nxt     = r_ap;
        w_uop        = xf(XFER_NONE);
        w_alu_ap     = 1'b0;
        w_reset_ir   = 1'b0;
        w_next_instr = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            IDLE: if (w_go) w_state_nxt = FETCH0;
            FETCH0: begin
                w_uop       = imm_fetch();
                w_reset_ir  = 1'b1;
                w_state_nxt = FETCH1;
            end
            FETCH1: begin
                w_uop       = xf(XFER_MD_MEM);
                w_state_nxt = FETCH2;
            end
            FETCH2: begin
                w_uop       = xf(XFER_IR_MD);
                w_state_nxt = DECODE;
            end
            // Class, length and AP select are captured here so IR activity in EXEC is ignored
            DECODE: begin
                w_class_nxt = w_dec_class;
                w_last_nxt  = w_dec_last;
                w_ap_nxt    = bus.i_ir[3] && (w_dec_class == CLS_ALI || w_dec_class == CLS_ALU);
                w_step_nxt  = 3'd0;
                if (w_dec_class == CLS_NOP) begin
                    w_next_instr = 1'b1;
                    w_state_nxt  = FETCH0;
                end else if (w_dec_class == CLS_HLT) begin
                    w_state_nxt  = HALT;
                end else begin
                    w_state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (r_step > STEP_MAX) begin
                    w_step_nxt  = 3'd0;
                    w_state_nxt = FETCH0;
                end else begin
                    w_uop    = exec_uop(r_class, r_step);
                    w_alu_ap = r_ap;
                    if (r_step == r_last_step) begin
                        w_next_instr = 1'b1;
                        w_step_nxt   = 3'd0;
                        w_state_nxt  = w_go ? FETCH0 : IDLE;
                    end else begin
                        w_step_nxt   = r_step + 3'd1;
                    end
                end
            end
            HALT:    w_halted    = 1'b1;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_transfer_cmd  = w_uop.cmd;
    assign bus.o_inc_pc        = w_uop.inc_pc;
    assign bus.o_inc_dec_sp    = w_uop.sp;
    assign bus.o_alu_calculate = w_uop.calc;
    assign bus.o_alu_res_to_ap = w_alu_ap;
    assign bus.o_reset_ir      = w_reset_ir;
    assign bus.o_next_instr    = w_next_instr;
    assign bus.o_halted        = w_halted;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction's expected cycle stream is
// expanded from a textual micro-op recipe and compared cycle by cycle.
module tb_control_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit #(.AUTO_RUN(1'b0)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit at_fetch = 1'b0;
    logic [11:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // {cmd, inc_pc, sp, calc, res_to_ap, reset_ir, next_instr, halted}
    function automatic logic [11:0] ex(input logic [3:0] cmd, input logic inc, input logic [1:0] sp,
                                       input logic calc, input logic ap, input logic rir,
                                       input logic ni, input logic hlt);
        return {cmd, inc, sp, calc, ap, rir, ni, hlt};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.o_transfer_cmd, bus.o_inc_pc, bus.o_inc_dec_sp, bus.o_alu_calculate,
                bus.o_alu_res_to_ap, bus.o_reset_ir, bus.o_next_instr, bus.o_halted};
    endfunction

    // Recipe: steps separated by ';', hex digit = command, '+' = inc_pc,
    // 'u' = SP+1, 'd' = SP-1, 'c' = ALU calculate, "H" = halt, "" = NOP.
    function automatic string recipe(input logic [7:0] op);
        case (op)
            8'h19, 8'h1B:        return "1+;2;5";
            8'h11, 8'h13:        return "1+;2;4;2;5";
            8'h14, 8'h1E:        return "6;2;5";
            8'hC1:               return "u;7;2;5";
            8'h21, 8'h23:        return "1+;2;4;8;9";
            8'h2C, 8'h2E:        return "7;8;9d";
            8'hA1, 8'hA5, 8'hA9: return "1+;2;B";
            8'hB0:               return "u;7;2;B";
            8'hE0:               return "7;F;9d;E";
            8'hF0:               return "C";
            8'hF1:               return "D";
            8'hFF:               return "H";
            default: ;
        endcase
        case (op[7:4])
            4'h3, 4'h6, 4'h7, 4'h8: return "1+;2;c;A";
            4'h5, 4'h9:             return "c;A";
            default:                return "";
        endcase
    endfunction

    function automatic logic [3:0] hexval(input byte c);
        int v;
        v = int'(c);
        if (v <= 57) return 4'(v - 48);
        return 4'(v - 55);
    endfunction

    task automatic build(input logic [7:0] op, input string r);
        logic [3:0] cmd;
        logic inc, calc, ap;
        logic [1:0] sp;
        logic [11:0] e;
        byte ch;
        exp_q.delete();
        exp_q.push_back(ex(4'h1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ex(4'h2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ex(4'h3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ex(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, r.len() == 0, 1'b0));
        if (r.len() == 0 || r == "H") return;
        ap = 1'b0;
        for (int i = 0; i < r.len(); i++) if (r.getc(i) == "c") ap = op[3];
        cmd = 4'h0; inc = 1'b0; sp = 2'b00; calc = 1'b0;
        for (int i = 0; i <= r.len(); i++) begin
            ch = (i < r.len()) ? r.getc(i) : ";";
            case (ch)
                ";": begin
                    exp_q.push_back(ex(cmd, inc, sp, calc, ap, 1'b0, 1'b0, 1'b0));
                    cmd = 4'h0; inc = 1'b0; sp = 2'b00; calc = 1'b0;
                end
                "+": inc  = 1'b1;
                "u": sp   = 2'b01;
                "d": sp   = 2'b10;
                "c": calc = 1'b1;
                default: cmd = hexval(ch);
            endcase
        end
        e = exp_q.pop_back();
        e[1] = 1'b1;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; runs one instruction and leaves the bench at the next one's start.
    task automatic run_instr(input logic [7:0] op, input int drop_at, input int rst_at);
        string r;
        r = recipe(op);
        build(op, r);
        bus.i_run = 1'b1;
        if (!at_fetch) begin
            bus.i_ir = op;
            chk("idle_before_fetch", obs(), 32'h0);
            @(negedge clk);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("op%02h_cyc%0d", op, i), obs(), exp_q[i]);
            if (i == rst_at) begin
                #2 rstn = 1'b0;
                #1 chk("async_reset_outputs", obs(), 32'h0);
                @(negedge clk);
                chk("reset_held_outputs", obs(), 32'h0);
                rstn = 1'b1;
                at_fetch = 1'b0;
                return;
            end
            bus.i_ir = (i <= 3) ? op : 8'($urandom);
            if (i == drop_at) bus.i_run = 1'b0;
            @(negedge clk);
        end
        if (r == "H") begin
            for (int k = 0; k < 20; k++) begin
                chk($sformatf("halted_cyc%0d", k), obs(), 32'h1);
                bus.i_run = 1'($urandom);
                bus.i_ir  = 8'($urandom);
                @(negedge clk);
            end
            rstn = 1'b0;
            @(negedge clk);
            chk("halt_cleared_by_reset", obs(), 32'h0);
            rstn = 1'b1;
            at_fetch = 1'b0;
        end else if (r.len() == 0) begin
            at_fetch = 1'b1;
        end else begin
            at_fetch = bus.i_run;
            if (!at_fetch) begin
                for (int k = 0; k < 3; k++) begin
                    chk("idle_after_run_drop", obs(), 32'h0);
                    @(negedge clk);
                end
            end
        end
    endtask

    logic [7:0] known [25] = '{8'h19, 8'h1B, 8'h11, 8'h13, 8'h14, 8'h1E, 8'hC1, 8'h21, 8'h23,
                               8'h2C, 8'h2E, 8'h3B, 8'h64, 8'h7A, 8'h85, 8'h50, 8'h9C, 8'hA1,
                               8'hA5, 8'hA9, 8'hB0, 8'hE0, 8'hF0, 8'hF1, 8'h00};

    initial begin
        logic [7:0] op;
        int drop;
        bus.i_run = 1'b0;
        bus.i_ir  = 8'h00;
        repeat (2) @(negedge clk);
        chk("outputs_in_reset", obs(), 32'h0);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("idle_no_run_%0d", k), obs(), 32'h0);
        end
        @(negedge clk);

        run_instr(8'h19, -1, -1);
        run_instr(8'h3B, -1, -1);
        run_instr(8'h50, -1, -1);
        run_instr(8'hE0, -1, -1);
        run_instr(8'hB0, -1, -1);
        run_instr(8'h11, 5, -1);
        run_instr(8'h07, -1, -1);
        run_instr(8'h2C, -1, 5);
        run_instr(8'hC1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 1) == 0) ? known[$urandom_range(0, 24)] : 8'($urandom);
            if (op == 8'hFF) op = 8'h00;
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_instr(op, drop, -1);
        end

        run_instr(8'hFF, -1, -1);
        run_instr(8'h9B, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
